burst_rr_arbiter: RTL and testbench
===================================

Name: burst_rr_arbiter

Overview:
- Round-robin arbiter that shares one resource between NUM_REQ requesters.
- A winning requester holds its grant for a burst of up to MAX_BURST consecutive transfer cycles, then must yield.
- Sits in front of any shared single-port resource: bus slave, counter/checker unit or memory port.
- Built to be formally checkable: grant-length bounds are expressible as simple [*N] repetition properties.

Parameters:
- NUM_REQ, 4, number of requesters; must be >= 2, elaboration error otherwise.
- MAX_BURST, 5, maximum consecutive transfer cycles per grant; must be >= 1, elaboration error otherwise.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  request per requester; level, sampled at posedge.
- gnt  output  NUM_REQ  one-hot-or-zero grant, registered.
- gnt_valid  output  1  OR of gnt, registered.
- gnt_id  output  $clog2(NUM_REQ)  index of current owner; 0 when gnt_valid=0.
- burst_cnt  output  $clog2(MAX_BURST+1)  transfers completed in the current burst.
- burst_done  output  1  one-cycle pulse: the previous burst ended by exhaustion (MAX_BURST transfers).

Behaviour:
- Reset (async assert, sync release by system): gnt=0, gnt_valid=0, gnt_id=0, burst_cnt=0, burst_done=0, state IDLE, rr pointer ptr=0. Reset mid-burst aborts the burst immediately; no pulse on burst_done.
- States: IDLE (no owner) and OWN (owner o = gnt_id).
- Transfer: a cycle where gnt[o]=1 and req[o]=1 at posedge.
- Latency: req rising in IDLE produces gnt at the next posedge (1 cycle). No combinational path from req to gnt.
- Pick function: first i with req[i]=1 scanning ptr, ptr+1, ... wrapping modulo NUM_REQ.
- IDLE:
  - If any req, grant pick(req), burst_cnt=0, ptr=winner+1 mod NUM_REQ, go to OWN.
  - Otherwise stay in IDLE.
- OWN, at each posedge:
  - Continue: req[o]=1 and burst_cnt+1 < MAX_BURST. Increment burst_cnt and keep gnt.
  - Exhaust: req[o]=1 and burst_cnt+1 == MAX_BURST. End the burst and assert burst_done next cycle. Re-arbitrate over req with bit o masked. If a winner exists, grant it back-to-back (no idle cycle) with burst_cnt=0; else go to IDLE. The exhausted owner is never re-granted at the same edge, so it sees at least one cycle with gnt low.
  - Withdraw: req[o]=0. End the burst with no burst_done pulse and no transfer counted. Re-arbitrate over req; o is masked implicitly because its req is low. Grant the winner back-to-back or go to IDLE.
- ptr always becomes new_owner+1 mod NUM_REQ on a new grant. It is unchanged on a transition to IDLE.
- MAX_BURST=1: every granted cycle that carries a transfer exhausts the burst. The block then behaves as a per-cycle round-robin arbiter with forced release.
- Invariants, required as embedded SVA under a define guard:
  - $onehot0(gnt) always.
  - gnt[i][*MAX_BURST+1] never occurs for any i.
  - gnt_valid == |gnt.
  - burst_cnt < MAX_BURST always.
  - Starvation bound: req[i] held continuously is granted within (NUM_REQ-1)*(MAX_BURST+1)+1 cycles. The bound allows a one-cycle gap for a withdraw, plus the grant latency cycle.
- Cover: gnt[i][*MAX_BURST] followed by !gnt[i], for each i.
- Width rule: all index arithmetic is modulo NUM_REQ, also when NUM_REQ is not a power of 2. The ptr wrap must never leave the range [0, NUM_REQ-1].

Decomposition:
- Package burst_rr_arbiter_pkg contains the state enum (IDLE, OWN) and a localparam helper for $clog2 widths.
- One combinational sub-module, rr_pick: inputs req vector, ptr and mask; outputs found and idx. It is instantiated once.
- The FSM, counters and registered outputs stay in burst_rr_arbiter.

Test Plan:
- Reset, then req=4'b0010 held → gnt=0010 one cycle later, held 5 cycles with burst_cnt 0..4. Then gnt=0 for one cycle, burst_done=1 in that cycle, then regrant of requester 1.
- req=4'b1111 held, MAX_BURST=5 → grants rotate 0,1,2,3,0 in 5-cycle back-to-back blocks with no gaps; burst_done pulses every 5 cycles.
- Requester 2 owns at burst_cnt=2 and drops req → gnt[2] falls at the next edge with no burst_done. A pending requester 3 is granted that same edge.
- Async rst_n asserted mid-burst (asynchronously, off the clock edge) → outputs zero immediately; after release with req=4'b1000, the grant goes to requester 3 one cycle later and ptr restarts from 0.
- NUM_REQ=3, MAX_BURST=1, req=3'b111 → gnt cycles 001, 010, 100, 001 every cycle. ptr wraps correctly and no index 3 appears.
- Formal run with the embedded SVA enabled: every assertion proven and every cover reached for the NUM_REQ=4, MAX_BURST=5 defaults.

Source files
------------

// File: rtl/burst_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// burst_rr_arbiter_pkg
// Shared types and width helpers for the burst round-robin arbiter.
//   state_t   : arbiter FSM state (IDLE = no owner, OWN = grant held)
//   width_for : bit width needed to encode values 0..n-1 (never below 1)
// ---------------------------------------------------------------------------
package burst_rr_arbiter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

   function automatic int width_for(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector: finds the first requester with
// req=1 and mask=0, scanning ptr, ptr+1, ... modulo NUM_REQ.
// Ports:
//   req   [NUM_REQ-1:0]  request vector
//   ptr   [IW-1:0]       scan start index, always within 0..NUM_REQ-1
//   mask  [NUM_REQ-1:0]  requesters excluded from this pick
//   found                at least one unmasked requester is active
//   idx   [IW-1:0]       winning index (0 when found=0)
// ---------------------------------------------------------------------------
module rr_pick
   import burst_rr_arbiter_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int IW      = width_for(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   input  logic [NUM_REQ-1:0] mask,
   output logic               found,
   output logic [IW-1:0]      idx
);

   logic [NUM_REQ-1:0] cand;
   logic [IW:0]        pos;

   assign cand = req & ~mask;

   // Scan from the farthest offset down to offset 0 so the nearest hit to
   // ptr is the last one written. The wrap is a single conditional
   // subtract, which keeps pos inside 0..NUM_REQ-1 for any NUM_REQ.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      pos   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         pos = {1'b0, ptr} + (IW+1)'(k);
         if (pos >= (IW+1)'(NUM_REQ))
            pos = pos - (IW+1)'(NUM_REQ);
         if (cand[pos[IW-1:0]]) begin
            found = 1'b1;
            idx   = pos[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/burst_rr_arbiter.sv
// ---------------------------------------------------------------------------
// burst_rr_arbiter
// Round-robin arbiter sharing one resource between NUM_REQ requesters.
// A winner keeps its grant for up to MAX_BURST transfer cycles, then is
// forced to release; dropping its request releases it early.
// Ports:
//   clk         clock, all state on posedge
//   rst_n       asynchronous active-low reset
//   req         [NUM_REQ-1:0] level requests
//   gnt         [NUM_REQ-1:0] registered one-hot-or-zero grant
//   gnt_valid   registered OR of gnt
//   gnt_id      index of the current owner, 0 when idle
//   burst_cnt   transfers completed in the current burst
//   burst_done  one-cycle pulse after a burst ends by exhaustion
// ---------------------------------------------------------------------------
module burst_rr_arbiter
   import burst_rr_arbiter_pkg::*;
#(
   parameter  int NUM_REQ   = 4,
   parameter  int MAX_BURST = 5,
   localparam int IW        = width_for(NUM_REQ),
   localparam int CW        = width_for(MAX_BURST + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic               gnt_valid,
   output logic [IW-1:0]      gnt_id,
   output logic [CW-1:0]      burst_cnt,
   output logic               burst_done
);

   if (NUM_REQ < 2) begin : g_bad_num_req
      $error("burst_rr_arbiter: NUM_REQ must be >= 2");
   end
   if (MAX_BURST < 1) begin : g_bad_max_burst
      $error("burst_rr_arbiter: MAX_BURST must be >= 1");
   end

   state_t             state_q, state_d;
   logic [IW-1:0]      ptr_q, ptr_d;
   logic [NUM_REQ-1:0] gnt_d;
   logic [IW-1:0]      id_d;
   logic [CW-1:0]      cnt_d;
   logic               done_d;

   logic               transfer;
   logic               exhaust;
   logic [NUM_REQ-1:0] pick_mask;
   logic               found;
   logic [IW-1:0]      win;
   logic [IW-1:0]      win_next;

   assign transfer = (state_q == OWN) && req[gnt_id];
   assign exhaust  = transfer && (burst_cnt == CW'(MAX_BURST - 1));

   // An exhausted owner is excluded from the re-arbitration at the same
   // edge; gnt is its one-hot, so it doubles as the mask.
   assign pick_mask = exhaust ? gnt : '0;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .mask  (pick_mask),
      .found (found),
      .idx   (win)
   );

   assign win_next = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt;
      id_d    = gnt_id;
      cnt_d   = burst_cnt;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d = OWN;
               gnt_d   = NUM_REQ'(1) << win;
               id_d    = win;
               cnt_d   = '0;
               ptr_d   = win_next;
            end
         end
         OWN: begin
            if (transfer && !exhaust) begin
               cnt_d = burst_cnt + 1'b1;
            end else begin
               // Exhaust or withdraw: hand over back-to-back if anyone waits.
               done_d = exhaust;
               if (found) begin
                  gnt_d = NUM_REQ'(1) << win;
                  id_d  = win;
                  cnt_d = '0;
                  ptr_d = win_next;
               end else begin
                  state_d = IDLE;
                  gnt_d   = '0;
                  id_d    = '0;
                  cnt_d   = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         gnt        <= '0;
         gnt_valid  <= 1'b0;
         gnt_id     <= '0;
         burst_cnt  <= '0;
         burst_done <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         gnt        <= gnt_d;
         gnt_valid  <= |gnt_d;
         gnt_id     <= id_d;
         burst_cnt  <= cnt_d;
         burst_done <= done_d;
      end
   end

`ifdef BURST_RR_ARBITER_SVA
   localparam int STARVE = (NUM_REQ - 1) * (MAX_BURST + 1) + 1;

   a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
   a_valid:  assert property (@(posedge clk) disable iff (!rst_n) gnt_valid == |gnt);
   a_cnt:    assert property (@(posedge clk) disable iff (!rst_n) burst_cnt < MAX_BURST);

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_sva
      a_burst_len: assert property (@(posedge clk) disable iff (!rst_n)
         not (gnt[i] [*MAX_BURST+1]));
      a_starve: assert property (@(posedge clk) disable iff (!rst_n)
         not ((req[i] && !gnt[i]) [*STARVE+1]));
      c_full_burst: cover property (@(posedge clk) disable iff (!rst_n)
         gnt[i] [*MAX_BURST] ##1 !gnt[i]);
   end
`endif

endmodule

// File: tb/tb_burst_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_burst_rr_arbiter
// Drives two arbiters (4 requesters / burst 5, and 3 requesters / burst 1)
// with directed and random request patterns. A cycle-level reference model
// predicts each cycle's outputs into a queue; a negedge monitor pops and
// compares against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_burst_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req_a;
   logic [2:0] req_b;

   logic [3:0] gnt_a;
   logic       gv_a;
   logic [1:0] id_a;
   logic [2:0] cnt_a;
   logic       done_a;

   logic [2:0] gnt_b;
   logic       gv_b;
   logic [1:0] id_b;
   logic       cnt_b;
   logic       done_b;

   always #5 clk = ~clk;

   burst_rr_arbiter #(.NUM_REQ(4), .MAX_BURST(5)) dut_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req_a),
      .gnt        (gnt_a),
      .gnt_valid  (gv_a),
      .gnt_id     (id_a),
      .burst_cnt  (cnt_a),
      .burst_done (done_a)
   );

   burst_rr_arbiter #(.NUM_REQ(3), .MAX_BURST(1)) dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req_b),
      .gnt        (gnt_b),
      .gnt_valid  (gv_b),
      .gnt_id     (id_b),
      .burst_cnt  (cnt_b),
      .burst_done (done_b)
   );

   // Model state: owner = -1 means nobody holds the resource.
   typedef struct {
      int owner;
      int cnt;
      int ptr;
      bit done;
   } mst_t;

   typedef struct {
      int gnt;
      int id;
      int cnt;
      bit done;
   } exp_t;

   mst_t ma;
   mst_t mb;
   exp_t qa[$];
   exp_t qb[$];
   int   n_pass  = 0;
   int   n_total = 0;
   bit   chk_en  = 1'b0;

   function automatic void mreset(output mst_t s);
      s.owner = -1;
      s.cnt   = 0;
      s.ptr   = 0;
      s.done  = 1'b0;
   endfunction

   // One posedge of the arbitration rules, given the sampled request mask r.
   function automatic void mstep(input int n, input int mbst, input int r, inout mst_t s);
      int masked;
      int w;
      bit rearb;
      masked = -1;
      w      = -1;
      rearb  = 1'b0;
      s.done = 1'b0;
      if (s.owner < 0) begin
         rearb = 1'b1;
      end else if (((r >> s.owner) & 1) != 0) begin
         if (s.cnt + 1 < mbst) begin
            s.cnt = s.cnt + 1;
         end else begin
            s.done = 1'b1;
            masked = s.owner;
            rearb  = 1'b1;
         end
      end else begin
         rearb = 1'b1;
      end
      if (rearb) begin
         for (int k = 0; k < n; k++) begin
            int i;
            i = (s.ptr + k) % n;
            if (w < 0 && i != masked && ((r >> i) & 1) != 0)
               w = i;
         end
         if (w >= 0) begin
            s.owner = w;
            s.cnt   = 0;
            s.ptr   = (w + 1) % n;
         end else begin
            s.owner = -1;
            s.cnt   = 0;
         end
      end
   endfunction

   function automatic exp_t mexp(input mst_t s);
      exp_t e;
      e.gnt  = (s.owner >= 0) ? (1 << s.owner) : 0;
      e.id   = (s.owner >= 0) ? s.owner : 0;
      e.cnt  = s.cnt;
      e.done = s.done;
      return e;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp)
         n_pass++;
      else
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
   endtask

   task automatic chk_zero_outputs();
      chk("rst_a_gnt",  int'(gnt_a),  0);
      chk("rst_a_gv",   int'(gv_a),   0);
      chk("rst_a_id",   int'(id_a),   0);
      chk("rst_a_cnt",  int'(cnt_a),  0);
      chk("rst_a_done", int'(done_a), 0);
      chk("rst_b_gnt",  int'(gnt_b),  0);
      chk("rst_b_gv",   int'(gv_b),   0);
      chk("rst_b_done", int'(done_b), 0);
   endtask

   // Monitor: every cycle after a model step, compare DUT to the prediction.
   always @(negedge clk) begin
      exp_t e;
      if (chk_en) begin
         if (qa.size() == 0) begin
            chk("a_queue_empty", 0, 1);
         end else begin
            e = qa.pop_front();
            chk("a_gnt",  int'(gnt_a),  e.gnt);
            chk("a_gv",   int'(gv_a),   (e.gnt != 0) ? 1 : 0);
            chk("a_id",   int'(id_a),   e.id);
            chk("a_cnt",  int'(cnt_a),  e.cnt);
            chk("a_done", int'(done_a), int'(e.done));
         end
         if (qb.size() == 0) begin
            chk("b_queue_empty", 0, 1);
         end else begin
            e = qb.pop_front();
            chk("b_gnt",  int'(gnt_b),  e.gnt);
            chk("b_gv",   int'(gv_b),   (e.gnt != 0) ? 1 : 0);
            chk("b_id",   int'(id_b),   e.id);
            chk("b_cnt",  int'(cnt_b),  e.cnt);
            chk("b_done", int'(done_b), int'(e.done));
         end
      end
   end

   // Called at a negedge: apply requests, step the models at the posedge.
   task automatic cyc(input logic [3:0] ra, input logic [2:0] rb);
      req_a = ra;
      req_b = rb;
      @(posedge clk);
      mstep(4, 5, int'(ra), ma);
      qa.push_back(mexp(ma));
      mstep(3, 1, int'(rb), mb);
      qb.push_back(mexp(mb));
      chk_en = 1'b1;
      @(negedge clk);
   endtask

   // Called at a negedge: assert reset off the clock edge, check outputs
   // clear at once, release at a later negedge.
   task automatic do_reset();
      #2;
      rst_n  = 1'b0;
      chk_en = 1'b0;
      qa.delete();
      qb.delete();
      mreset(ma);
      mreset(mb);
      #1;
      chk_zero_outputs();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [3:0] ra;
      logic [2:0] rb;
      int         hold;
      rst_n = 1'b1;
      req_a = '0;
      req_b = '0;
      mreset(ma);
      mreset(mb);
      @(negedge clk);
      do_reset();

      // Single requester: full burst, forced gap, regrant.
      repeat (14) cyc(4'b0010, 3'b111);
      // Everybody requesting: back-to-back rotation.
      repeat (30) cyc(4'b1111, 3'b111);
      repeat (3) cyc(4'b0000, 3'b000);
      // Requester 2 owns for a few cycles, then withdraws with 3 pending.
      repeat (3) cyc(4'b0100, 3'b101);
      repeat (8) cyc(4'b1000, 3'b011);
      // Reset in the middle of requester 3's burst.
      repeat (2) cyc(4'b1000, 3'b110);
      do_reset();
      repeat (10) cyc(4'b1000, 3'b001);

      // Random patterns held for random lengths, with occasional resets.
      for (int n = 0; n < 1600; n++) begin
         ra   = 4'($urandom_range(0, 15));
         rb   = 3'($urandom_range(0, 7));
         hold = $urandom_range(1, 8);
         for (int h = 0; h < hold; h++)
            cyc(ra, rb);
         if ((n % 500) == 499)
            do_reset();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
